ssrv_memarb: RTL and testbench

//  Shares one memory bus between the core's imem (fetch) and dmem (load/store) ports.

---
 rtl/ssrv_memarb.sv | 169 ++++++++++++++++
 tb/tb_ssrv_memarb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssrv_memarb.sv
// rtl/ssrv_memarb.sv - two-port (fetch/data) memory bus arbiter with anti-starvation.
// One bus transaction in flight; fetch gets the bus after FAIR_CNT data grants while it waits.
module ssrv_memarb #(
  parameter int XLEN     = 32,
  parameter int BUS_WID  = 64,
  parameter int FAIR_CNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               imem_req,
  input  logic [XLEN-1:0]    imem_addr,
  output logic [BUS_WID-1:0] imem_rdata,
  output logic               imem_resp,
  input  logic               dmem_req,
  input  logic               dmem_cmd,
  input  logic [1:0]         dmem_width,
  input  logic [XLEN-1:0]    dmem_addr,
  input  logic [XLEN-1:0]    dmem_wdata,
  output logic [XLEN-1:0]    dmem_rdata,
  output logic               dmem_resp,
  output logic               bus_req,
  output logic               bus_cmd,
  output logic [1:0]         bus_width,
  output logic [XLEN-1:0]    bus_addr,
  output logic [BUS_WID-1:0] bus_wdata,
  input  logic [BUS_WID-1:0] bus_rdata,
  input  logic               bus_resp
);

  localparam int NLANES = BUS_WID / XLEN;
  localparam int LIDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_CNT);

  typedef enum logic [1:0] {IDLE, IWAIT, DWAIT} state_t;

  state_t              state_q, state_d;
  logic                ipend_q, ipend_d;
  logic                dpend_q, dpend_d;
  logic [XLEN-1:0]     iaddr_q, iaddr_d;
  logic                dcmd_q, dcmd_d;
  logic [1:0]          dwidth_q, dwidth_d;
  logic [XLEN-1:0]     daddr_q, daddr_d;
  logic [XLEN-1:0]     dwdata_q, dwdata_d;
  logic [3:0]          fair_q, fair_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_cmd_q, bus_cmd_d;
  logic [1:0]          bus_width_q, bus_width_d;
  logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
  logic [BUS_WID-1:0]  bus_wdata_q, bus_wdata_d;

  logic [LIDX_W-1:0]   lane_idx;
  logic [XLEN-1:0]     lane, shifted, mask;

  // Responses are gated by rst so an abort never leaks a resp in the reset cycle.
  assign imem_resp = rst && (state_q == IWAIT) && bus_resp;
  assign dmem_resp = rst && (state_q == DWAIT) && bus_resp;

  assign lane_idx = (NLANES > 1) ? daddr_q[2 +: LIDX_W] : '0;

  always_comb begin
    lane    = bus_rdata[int'(lane_idx) * XLEN +: XLEN];
    shifted = lane >> {daddr_q[1:0], 3'b000};
    case (dwidth_q)
      2'd0:    mask = XLEN'(32'h0000_00FF);
      2'd1:    mask = XLEN'(32'h0000_FFFF);
      default: mask = '1;
    endcase
    dmem_rdata = dmem_resp ? (shifted & mask) : '0;
    imem_rdata = imem_resp ? bus_rdata : '0;
  end

  assign bus_req   = bus_req_q;
  assign bus_cmd   = bus_cmd_q;
  assign bus_width = bus_width_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    state_d     = state_q;
    ipend_d     = ipend_q;
    dpend_d     = dpend_q;
    iaddr_d     = iaddr_q;
    dcmd_d      = dcmd_q;
    dwidth_d    = dwidth_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    fair_d      = ipend_q ? fair_q : 4'd0;
    bus_req_d   = 1'b0;
    bus_cmd_d   = bus_cmd_q;
    bus_width_d = bus_width_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    if (imem_resp) ipend_d = 1'b0;
    if (dmem_resp) dpend_d = 1'b0;
    // A new request in the same cycle as its own resp is accepted; otherwise a pending port drops it.
    if (imem_req && (!ipend_q || imem_resp)) begin
      ipend_d = 1'b1;
      iaddr_d = imem_addr;
    end
    if (dmem_req && (!dpend_q || dmem_resp)) begin
      dpend_d  = 1'b1;
      dcmd_d   = dmem_cmd;
      dwidth_d = dmem_width;
      daddr_d  = dmem_addr;
      dwdata_d = dmem_wdata;
    end

    case (state_q)
      IDLE: begin
        if (dpend_q && !(ipend_q && fair_q == FAIR_MAX)) begin
          state_d     = DWAIT;
          bus_req_d   = 1'b1;
          bus_cmd_d   = dcmd_q;
          bus_width_d = dwidth_q;
          bus_addr_d  = daddr_q;
          bus_wdata_d = {NLANES{dwdata_q}};
          if (ipend_q && fair_q != FAIR_MAX) fair_d = fair_q + 4'd1;
        end else if (ipend_q) begin
          state_d     = IWAIT;
          bus_req_d   = 1'b1;
          bus_cmd_d   = 1'b0;
          bus_width_d = 2'd3;
          bus_addr_d  = iaddr_q;
          bus_wdata_d = '0;
          fair_d      = 4'd0;
        end
      end
      IWAIT:   if (imem_resp) state_d = IDLE;
      DWAIT:   if (dmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ipend_q     <= 1'b0;
      dpend_q     <= 1'b0;
      iaddr_q     <= '0;
      dcmd_q      <= 1'b0;
      dwidth_q    <= 2'd0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      fair_q      <= 4'd0;
      bus_req_q   <= 1'b0;
      bus_cmd_q   <= 1'b0;
      bus_width_q <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ipend_q     <= ipend_d;
      dpend_q     <= dpend_d;
      iaddr_q     <= iaddr_d;
      dcmd_q      <= dcmd_d;
      dwidth_q    <= dwidth_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      fair_q      <= fair_d;
      bus_req_q   <= bus_req_d;
      bus_cmd_q   <= bus_cmd_d;
      bus_width_q <= bus_width_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_ssrv_memarb.sv
// tb/tb_ssrv_memarb.sv - directed bench for ssrv_memarb.
module tb_ssrv_memarb;
  localparam int XLEN = 32;
  localparam int BUS_WID = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               imem_req = 1'b0;
  logic [XLEN-1:0]    imem_addr = '0;
  logic [BUS_WID-1:0] imem_rdata;
  logic               imem_resp;
  logic               dmem_req = 1'b0;
  logic               dmem_cmd = 1'b0;
  logic [1:0]         dmem_width = 2'd0;
  logic [XLEN-1:0]    dmem_addr = '0;
  logic [XLEN-1:0]    dmem_wdata = '0;
  logic [XLEN-1:0]    dmem_rdata;
  logic               dmem_resp;
  logic               bus_req;
  logic               bus_cmd;
  logic [1:0]         bus_width;
  logic [XLEN-1:0]    bus_addr;
  logic [BUS_WID-1:0] bus_wdata;
  logic [BUS_WID-1:0] bus_rdata = '0;
  logic               bus_resp = 1'b0;

  int errors = 0;
  int checks = 0;
  int nbusreq = 0;

  ssrv_memarb #(.XLEN(XLEN), .BUS_WID(BUS_WID), .FAIR_CNT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_width(bus_width), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_resp(bus_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_req === 1'b1) nbusreq++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_busreq(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus_req === 1'b1) begin
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %0h exp 0", bus_req); end
    checks++; if (bus_addr !== '0 || bus_width !== 2'd0 || bus_cmd !== 1'b0) begin
      errors++; $display("FAIL rst_bus_fields: addr %0h width %0h cmd %0h exp 0", bus_addr, bus_width, bus_cmd); end
    checks++; if (bus_wdata !== '0) begin errors++; $display("FAIL rst_bus_wdata: got %0h exp 0", bus_wdata); end
    checks++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0) begin
      errors++; $display("FAIL rst_resp: imem %0h dmem %0h exp 0", imem_resp, dmem_resp); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_imem_fetch();
    int c, base;
    base = nbusreq;
    imem_req = 1'b1; imem_addr = 32'h100;
    tick();
    imem_req = 1'b0;
    wait_busreq(c);
    checks++; if (c !== 1) begin errors++; $display("FAIL t1_latency: got %0d exp 1", c); end
    checks++; if (bus_addr !== 32'h100 || bus_width !== 2'd3 || bus_cmd !== 1'b0) begin
      errors++; $display("FAIL t1_bus_fields: addr %0h width %0h cmd %0h exp 100/3/0", bus_addr, bus_width, bus_cmd); end
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL t1_req_pulse: got %0h exp 0", bus_req); end
    imem_req = 1'b1; imem_addr = 32'h200;   // dropped: fetch already pending
    tick();
    imem_req = 1'b0;
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL t1_addr_hold: got %0h exp 100", bus_addr); end
    tick();
    bus_resp = 1'b1; bus_rdata = 64'hDEAD_BEEF_0123_4567;
    #1;
    checks++; if (imem_resp !== 1'b1 || dmem_resp !== 1'b0) begin
      errors++; $display("FAIL t1_resp: imem %0h dmem %0h exp 1/0", imem_resp, dmem_resp); end
    checks++; if (imem_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      errors++; $display("FAIL t1_rdata: got %0h exp deadbeef01234567", imem_rdata); end
    tick();
    bus_resp = 1'b0;
    #1;
    checks++; if (imem_resp !== 1'b0 || imem_rdata !== '0) begin
      errors++; $display("FAIL t1_resp_end: resp %0h rdata %0h exp 0/0", imem_resp, imem_rdata); end
    repeat (6) tick();
    checks++; if (nbusreq - base !== 1) begin errors++; $display("FAIL t1_busreq_count: got %0d exp 1", nbusreq - base); end
  endtask

  task automatic test_simultaneous();
    int c, base;
    base = nbusreq;
    imem_req = 1'b1; imem_addr = 32'h300;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h204;
    tick();
    imem_req = 1'b0; dmem_req = 1'b0;
    wait_busreq(c);
    checks++; if (c < 0 || bus_width !== 2'd2 || bus_addr !== 32'h204) begin
      errors++; $display("FAIL t2_first_dmem: cyc %0d width %0h addr %0h exp dmem 2/204", c, bus_width, bus_addr); end
    tick();
    bus_resp = 1'b1; bus_rdata = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (dmem_resp !== 1'b1 || imem_resp !== 1'b0) begin
      errors++; $display("FAIL t2_dresp: dmem %0h imem %0h exp 1/0", dmem_resp, imem_resp); end
    checks++; if (dmem_rdata !== 32'h1122_3344) begin errors++; $display("FAIL t2_dword_lane1: got %0h exp 11223344", dmem_rdata); end
    tick();
    bus_resp = 1'b0;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL t2_idle_gap: got %0h exp 0", bus_req); end
    wait_busreq(c);
    checks++; if (c < 0 || bus_width !== 2'd3 || bus_addr !== 32'h300) begin
      errors++; $display("FAIL t2_second_imem: cyc %0d width %0h addr %0h exp 3/300", c, bus_width, bus_addr); end
    tick();
    bus_resp = 1'b1;
    #1;
    checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL t2_iresp: got %0h exp 1", imem_resp); end
    tick();
    bus_resp = 1'b0;
    repeat (6) tick();
    checks++; if (nbusreq - base !== 2) begin errors++; $display("FAIL t2_busreq_count: got %0d exp 2", nbusreq - base); end
  endtask

  task automatic test_fairness();
    int c, dgrants;
    bit igot, tmo;
    dgrants = 0; igot = 1'b0; tmo = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h400;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h40;
    tick();
    imem_req = 1'b0; dmem_req = 1'b0;
    for (int g = 0; g < 8 && !igot && !tmo; g++) begin
      wait_busreq(c);
      if (c < 0) tmo = 1'b1;
      else begin
        if (bus_width === 2'd3) igot = 1'b1;
        else dgrants++;
        tick();
        bus_resp = 1'b1;
        dmem_req = !igot;
        tick();
        bus_resp = 1'b0; dmem_req = 1'b0;
      end
    end
    checks++; if (!igot || tmo) begin errors++; $display("FAIL t3_imem_granted: got %0d exp 1", igot && !tmo); end
    checks++; if (dgrants !== 4) begin errors++; $display("FAIL t3_dgrants: got %0d exp 4", dgrants); end
    wait_busreq(c);
    checks++; if (c < 0 || bus_width !== 2'd2) begin
      errors++; $display("FAIL t3_drain_dmem: cyc %0d width %0h exp 2", c, bus_width); end
    tick();
    bus_resp = 1'b1;
    tick();
    bus_resp = 1'b0;
    tick();
  endtask

  task automatic test_byte_load();
    logic [XLEN-1:0] addrs [5] = '{32'h1003, 32'h1006, 32'h1004, 32'h1000, 32'h1002};
    logic [1:0]      wids  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [XLEN-1:0] exps  [5] = '{32'h0000_00AA, 32'h0000_5566, 32'h5566_7788, 32'h0000_00DD, 32'h0000_AABB};
    int c;
    for (int v = 0; v < 5; v++) begin
      dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = wids[v]; dmem_addr = addrs[v];
      tick();
      dmem_req = 1'b0;
      wait_busreq(c);
      checks++; if (c < 0 || bus_addr !== addrs[v] || bus_width !== wids[v]) begin
        errors++; $display("FAIL t4_bus_%0d: cyc %0d addr %0h width %0h", v, c, bus_addr, bus_width); end
      tick();
      bus_resp = 1'b1; bus_rdata = 64'h5566_7788_AABB_CCDD;
      #1;
      checks++; if (dmem_rdata !== exps[v]) begin
        errors++; $display("FAIL t4_rdata_%0d: got %0h exp %0h", v, dmem_rdata, exps[v]); end
      tick();
      bus_resp = 1'b0;
      tick();
    end
  endtask

  task automatic test_store();
    int c;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h8; dmem_wdata = 32'h1234_5678;
    tick();
    dmem_req = 1'b0; dmem_wdata = 32'hFFFF_FFFF;
    wait_busreq(c);
    checks++; if (c < 0 || bus_cmd !== 1'b1 || bus_width !== 2'd2 || bus_addr !== 32'h8) begin
      errors++; $display("FAIL t5_fields: cyc %0d cmd %0h width %0h addr %0h exp 1/2/8", c, bus_cmd, bus_width, bus_addr); end
    checks++; if (bus_wdata !== 64'h1234_5678_1234_5678) begin
      errors++; $display("FAIL t5_wdata: got %0h exp 1234567812345678", bus_wdata); end
    repeat (2) tick();
    checks++; if (bus_req !== 1'b0 || bus_wdata !== 64'h1234_5678_1234_5678 || bus_cmd !== 1'b1) begin
      errors++; $display("FAIL t5_hold: req %0h wdata %0h cmd %0h", bus_req, bus_wdata, bus_cmd); end
    bus_resp = 1'b1;
    #1;
    checks++; if (dmem_resp !== 1'b1) begin errors++; $display("FAIL t5_resp: got %0h exp 1", dmem_resp); end
    tick();
    bus_resp = 1'b0;
    tick();
  endtask

  task automatic test_spurious_and_abort();
    int c, base;
    bus_resp = 1'b1;
    #1;
    checks++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0) begin
      errors++; $display("FAIL t6_spurious: imem %0h dmem %0h exp 0/0", imem_resp, dmem_resp); end
    tick();
    bus_resp = 1'b0;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h500;
    tick();
    dmem_req = 1'b0;
    wait_busreq(c);
    checks++; if (c < 0) begin errors++; $display("FAIL t6_issue: got %0d exp >=0", c); end
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus_resp = 1'b1;
    #1;
    checks++; if (dmem_resp !== 1'b0 || imem_resp !== 1'b0) begin
      errors++; $display("FAIL t6_abort_resp: dmem %0h imem %0h exp 0/0", dmem_resp, imem_resp); end
    checks++; if (bus_addr !== '0) begin errors++; $display("FAIL t6_abort_addr: got %0h exp 0", bus_addr); end
    tick();
    bus_resp = 1'b0;
    base = nbusreq;
    repeat (6) tick();
    checks++; if (nbusreq - base !== 0) begin errors++; $display("FAIL t6_pend_cleared: got %0d exp 0", nbusreq - base); end
  endtask

  initial begin
    tick();
    test_reset();
    test_imem_fetch();
    test_simultaneous();
    test_fairness();
    test_byte_load();
    test_store();
    test_spurious_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
